// File: rtl/weighted_round_robin.sv
// Weighted round-robin arbiter: grants one of QUEUE_QUANTITY FIFOs at a time for up
// to weight[q] pops, with a one-cycle idle bubble between turns and a rotating search pointer.
module weighted_round_robin #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int WEIGHT_BITS    = 3,
    parameter int WEIGHTED       = 1,
    parameter int SEL_BITS       = $clog2(QUEUE_QUANTITY)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_enb,
    input  logic [QUEUE_QUANTITY-1:0]             i_buf_empty,
    input  logic [QUEUE_QUANTITY-1:0]             i_queue_mask,
    input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] i_weights,
    input  logic                                  i_pop,
    output logic [SEL_BITS-1:0]                   o_selector,
    output logic                                  o_selector_enb,
    output logic [QUEUE_QUANTITY-1:0]             o_grant,
    output logic [WEIGHT_BITS-1:0]                o_credit,
    output logic                                  o_pop_err
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam int                  CW     = SEL_BITS + 1;
    localparam logic [SEL_BITS-1:0] LAST_Q = SEL_BITS'(QUEUE_QUANTITY - 1);

    state_t                  r_state, w_state_nxt;
    logic [SEL_BITS-1:0]     r_selector, w_selector_nxt;
    logic [SEL_BITS-1:0]     r_ptr, w_ptr_nxt;
    logic [WEIGHT_BITS-1:0]  r_credit, w_credit_nxt;
    logic                    r_pop_err, w_pop_err_nxt;

    logic [QUEUE_QUANTITY-1:0] w_eligible;
    logic                      w_found;
    logic [SEL_BITS-1:0]       w_idx;
    logic [WEIGHT_BITS-1:0]    w_weight_raw;
    logic [WEIGHT_BITS-1:0]    w_weight_eff;
    logic                      w_release;

    assign w_eligible = i_queue_mask & ~i_buf_empty;

    // Scan ptr..ptr+N-1 with an explicit wrap so non-power-of-two counts never reach index N.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            automatic logic [CW-1:0] cand = {1'b0, r_ptr} + CW'(i);
            if (cand >= CW'(QUEUE_QUANTITY)) cand = cand - CW'(QUEUE_QUANTITY);
            if (!w_found && w_eligible[cand[SEL_BITS-1:0]]) begin
                w_found = 1'b1;
                w_idx   = cand[SEL_BITS-1:0];
            end
        end
    end

    assign w_weight_raw = i_weights[w_idx*WEIGHT_BITS +: WEIGHT_BITS];
    assign w_weight_eff = (WEIGHTED == 0 || w_weight_raw == '0) ? WEIGHT_BITS'(1) : w_weight_raw;

    // Losing eligibility wins over pop accounting; a final pop also ends the turn.
    assign w_release = i_buf_empty[r_selector] || !i_queue_mask[r_selector] ||
                       (i_pop && r_credit == WEIGHT_BITS'(1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_state_nxt    = r_state;
        w_selector_nxt = r_selector;
        w_ptr_nxt      = r_ptr;
        w_credit_nxt   = r_credit;
        w_pop_err_nxt  = 1'b0;
        if (i_enb) begin
            case (r_state)
                S_IDLE: begin
                    w_pop_err_nxt = i_pop;
                    if (w_found) begin
                        w_state_nxt    = S_GRANT;
                        w_selector_nxt = w_idx;
                        w_credit_nxt   = w_weight_eff;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        w_state_nxt  = S_IDLE;
                        w_credit_nxt = '0;
                        w_ptr_nxt    = (r_selector == LAST_Q) ? '0 : r_selector + 1'b1;
                    end else if (i_pop) begin
                        w_credit_nxt = r_credit - 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_selector <= '0;
            r_ptr      <= '0;
            r_credit   <= '0;
            r_pop_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_selector <= w_selector_nxt;
            r_ptr      <= w_ptr_nxt;
            r_credit   <= w_credit_nxt;
            r_pop_err  <= w_pop_err_nxt;
        end
    end

    always_comb begin
        o_grant = '0;
        if (r_state == S_GRANT) o_grant[r_selector] = 1'b1;
    end

    assign o_selector     = r_selector;
    assign o_selector_enb = (r_state == S_GRANT);
    assign o_credit       = r_credit;
    assign o_pop_err      = r_pop_err;

endmodule

// File: tb/tb_weighted_round_robin.sv
// Bench for weighted_round_robin: directed vector table, hand sequences for multi-cycle
// corners (N=3 wrap, unweighted mode, async reset) and a randomized run against a queue-level model.
module tb_weighted_round_robin;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        pop;
    logic [3:0]  empty, mask, mask_nw;
    logic [11:0] weights;
    logic [2:0]  empty3, mask3;
    logic [8:0]  weights3;

    logic [1:0]  sel, sel_nw, sel3;
    logic        sel_enb, sel_enb_nw, sel_enb3;
    logic [3:0]  grant, grant_nw;
    logic [2:0]  grant3;
    logic [2:0]  credit, credit_nw, credit3;
    logic        pop_err, pop_err_nw, pop_err3;

    int n_tests = 0;
    int n_fail  = 0;

    weighted_round_robin #(.QUEUE_QUANTITY(4), .WEIGHT_BITS(3), .WEIGHTED(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_enb(enb), .i_buf_empty(empty), .i_queue_mask(mask),
        .i_weights(weights), .i_pop(pop), .o_selector(sel), .o_selector_enb(sel_enb),
        .o_grant(grant), .o_credit(credit), .o_pop_err(pop_err));

    weighted_round_robin #(.QUEUE_QUANTITY(4), .WEIGHT_BITS(3), .WEIGHTED(0)) dut_nw (
        .i_clk(clk), .i_rst(rst), .i_enb(enb), .i_buf_empty(empty), .i_queue_mask(mask_nw),
        .i_weights(weights), .i_pop(pop), .o_selector(sel_nw), .o_selector_enb(sel_enb_nw),
        .o_grant(grant_nw), .o_credit(credit_nw), .o_pop_err(pop_err_nw));

    weighted_round_robin #(.QUEUE_QUANTITY(3), .WEIGHT_BITS(3), .WEIGHTED(1)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_enb(enb), .i_buf_empty(empty3), .i_queue_mask(mask3),
        .i_weights(weights3), .i_pop(pop), .o_selector(sel3), .o_selector_enb(sel_enb3),
        .o_grant(grant3), .o_credit(credit3), .o_pop_err(pop_err3));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       enb;
        logic [3:0] empty;
        logic [3:0] mask;
        logic       pop;
        logic [1:0] sel;
        logic       sel_enb;
        logic [2:0] cred;
        logic       err;
    } vec_t;

    vec_t vecs[17];

    // Reference model state (queue-level view of the arbiter).
    bit m_gnt;
    int m_sel, m_cred, m_ptr;
    bit m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic check_main(input string tag, input logic [1:0] s, input logic e,
                              input logic [2:0] c, input logic err);
        logic [3:0] g;
        g = e ? (4'b0001 << s) : 4'b0000;
        check({tag, ".selector"}, 32'(sel), 32'(s));
        check({tag, ".selector_enb"}, 32'(sel_enb), 32'(e));
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".credit"}, 32'(credit), 32'(c));
        check({tag, ".pop_err"}, 32'(pop_err), 32'(err));
    endtask

    function automatic int weight_of(input int q);
        int w;
        w = (int'(weights) >> (q * 3)) & 7;
        return (w == 0) ? 1 : w;
    endfunction

    // One clock of the arbitration rules, applied to the inputs currently being driven.
    task automatic model_step();
        bit nerr;
        nerr = 1'b0;
        if (enb) begin
            if (!m_gnt) begin
                nerr = pop;
                for (int k = 0; k < 4; k++) begin
                    int q;
                    q = (m_ptr + k) % 4;
                    if (mask[q] && !empty[q]) begin
                        m_gnt  = 1'b1;
                        m_sel  = q;
                        m_cred = weight_of(q);
                        break;
                    end
                end
            end else if (empty[m_sel] || !mask[m_sel] || (pop && m_cred == 1)) begin
                m_gnt  = 1'b0;
                m_cred = 0;
                m_ptr  = (m_sel + 1) % 4;
            end else if (pop) begin
                m_cred = m_cred - 1;
            end
        end
        m_err = nerr;
    endtask

    initial begin
        rst = 1'b0; enb = 1'b1; pop = 1'b0;
        empty = 4'b0000; mask = 4'b0000; mask_nw = 4'b0000;
        weights = {3'd0, 3'd2, 3'd1, 3'd3};
        empty3 = 3'b000; mask3 = 3'b000; weights3 = {3'd1, 3'd1, 3'd1};

        //                 enb   empty    mask     pop   sel   s_en  cred  err
        vecs[0]  = '{1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1, 3'd3, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 2'd0, 1'b1, 3'd2, 1'b0};
        vecs[2]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 2'd0, 1'b1, 3'd1, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0};
        vecs[4]  = '{1'b1, 4'b0000, 4'b1111, 1'b0, 2'd1, 1'b1, 3'd1, 1'b0};
        vecs[5]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 2'd1, 1'b0, 3'd0, 1'b0};
        vecs[6]  = '{1'b1, 4'b0000, 4'b1111, 1'b0, 2'd2, 1'b1, 3'd2, 1'b0};
        vecs[7]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 2'd2, 1'b1, 3'd1, 1'b0};
        vecs[8]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 2'd2, 1'b0, 3'd0, 1'b0};
        vecs[9]  = '{1'b1, 4'b0000, 4'b1111, 1'b0, 2'd3, 1'b1, 3'd1, 1'b0};
        vecs[10] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 2'd3, 1'b0, 3'd0, 1'b0};
        vecs[11] = '{1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1, 3'd3, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0, 1'b1, 3'd3, 1'b0};
        vecs[13] = '{1'b1, 4'b0001, 4'b1111, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0};
        vecs[14] = '{1'b1, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0, 3'd0, 1'b1};
        vecs[15] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0};
        vecs[16] = '{1'b1, 4'b0000, 4'b1010, 1'b0, 2'd1, 1'b1, 3'd1, 1'b0};

        #3;
        check_main("reset", 2'd0, 1'b0, 3'd0, 1'b0);
        #9;
        rst = 1'b1;

        // Directed table: weights q0=3 q1=1 q2=2 q3=0, enable hold, release on empty, pop_err.
        foreach (vecs[i]) begin
            enb = vecs[i].enb; empty = vecs[i].empty; mask = vecs[i].mask; pop = vecs[i].pop;
            tick();
            check_main($sformatf("vec%0d", i), vecs[i].sel, vecs[i].sel_enb, vecs[i].cred, vecs[i].err);
        end

        // q1 granted with credit 3, empties after one pop; next search starts at q2.
        enb = 1'b1; pop = 1'b0; empty = 4'b0000; mask = 4'b0010;
        weights = {3'd1, 3'd2, 3'd3, 3'd1};
        pulse_reset();
        tick();
        check_main("q1_grant", 2'd1, 1'b1, 3'd3, 1'b0);
        pop = 1'b1;
        tick();
        check_main("q1_pop", 2'd1, 1'b1, 3'd2, 1'b0);
        pop = 1'b0; empty = 4'b0010;
        tick();
        check_main("q1_empty_release", 2'd1, 1'b0, 3'd0, 1'b0);
        mask = 4'b1111;
        tick();
        check_main("after_q1_ptr2", 2'd2, 1'b1, 3'd2, 1'b0);

        // Asynchronous reset mid-turn on q2, then restart from q0.
        #2;
        rst = 1'b0;
        #1;
        check_main("async_reset", 2'd0, 1'b0, 3'd0, 1'b0);
        empty = 4'b0000; mask = 4'b1110;
        #1;
        rst = 1'b1;
        tick();
        check_main("post_reset_grant", 2'd1, 1'b1, 3'd3, 1'b0);

        // Randomized run against the reference model.
        mask = 4'b0000;
        pulse_reset();
        m_gnt = 1'b0; m_sel = 0; m_cred = 0; m_ptr = 0; m_err = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            enb = ($urandom_range(0, 7) != 0);
            pop = $urandom_range(0, 1) == 1;
            for (int q = 0; q < 4; q++) begin
                empty[q] = ($urandom_range(0, 3) == 0);
                mask[q]  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 15) == 0) weights = 12'($urandom);
            model_step();
            tick();
            check_main($sformatf("rand%0d", c), 2'(m_sel), m_gnt, 3'(m_cred), m_err);
        end

        // N=3: only q0 and q2 eligible; the pointer must wrap from q2 back to q0.
        enb = 1'b1; pop = 1'b0; mask = 4'b0000; mask_nw = 4'b0000;
        empty3 = 3'b000; mask3 = 3'b101;
        pulse_reset();
        tick();
        check("n3_grant_a", 32'(grant3), 32'(3'b001));
        pop = 1'b1;
        tick();
        check("n3_release_a", 32'(sel_enb3), 32'(1'b0));
        pop = 1'b0;
        tick();
        check("n3_grant_b", 32'(grant3), 32'(3'b100));
        check("n3_sel_b", 32'(sel3), 32'(2'd2));
        pop = 1'b1;
        tick();
        check("n3_release_b", 32'(sel_enb3), 32'(1'b0));
        pop = 1'b0;
        tick();
        check("n3_grant_wrap", 32'(grant3), 32'(3'b001));
        check("n3_sel_wrap", 32'(sel3), 32'(2'd0));

        // WEIGHTED=0: every turn is a single pop regardless of programmed weights.
        mask3 = 3'b000; mask_nw = 4'b1111; empty = 4'b0000;
        weights = {3'd0, 3'd2, 3'd1, 3'd3};
        pulse_reset();
        tick();
        check("nw_grant_q0", 32'(grant_nw), 32'(4'b0001));
        check("nw_credit_q0", 32'(credit_nw), 32'd1);
        pop = 1'b1;
        tick();
        check("nw_release_q0", 32'(sel_enb_nw), 32'(1'b0));
        pop = 1'b0;
        tick();
        check("nw_grant_q1", 32'(grant_nw), 32'(4'b0010));
        pop = 1'b1;
        tick();
        check("nw_release_q1", 32'(sel_enb_nw), 32'(1'b0));
        pop = 1'b0;
        tick();
        check("nw_grant_q2", 32'(grant_nw), 32'(4'b0100));
        check("nw_credit_q2", 32'(credit_nw), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/weighted_round_robin.md
Name: weighted_round_robin

Overview:
- Parametrised weighted round-robin arbiter. Selects which of QUEUE_QUANTITY input FIFOs feeds the shared output path.
- Generalises the fixed 4-queue rotating selector in three ways:
  - any queue count (power of two or not);
  - per-queue programmable burst weights, so a granted queue keeps the grant for up to weight[q] pops;
  - a per-queue enable mask.
- Sits between the FIFO bank (consumes buf_empty) and the output mux/downstream consumer (drives selector, receives pop).

Parameters:
- QUEUE_QUANTITY, 4, number of queues arbitrated; legal range ≥2.
- WEIGHT_BITS, 3, width of each per-queue weight field.
- WEIGHTED, 1, 1 = weights honoured; 0 = every weight treated as 1 (plain round robin).
- SEL_BITS, $clog2(QUEUE_QUANTITY), selector width; derived, never overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- enb  in  1  block enable; 0 freezes all state.
- buf_empty  in  QUEUE_QUANTITY  bit q = 1 when FIFO q is empty.
- queue_mask  in  QUEUE_QUANTITY  bit q = 1 makes queue q eligible.
- weights  in  QUEUE_QUANTITY*WEIGHT_BITS  weight of queue q at bits [q*WEIGHT_BITS +: WEIGHT_BITS].
- pop  in  1  downstream consumed one word from the selected queue this cycle.
- selector  out  SEL_BITS  index of the granted queue (registered).
- selector_enb  out  1  1 = selector valid and a grant is active (registered).
- grant  out  QUEUE_QUANTITY  one-hot grant; equals 1<<selector when selector_enb=1, else 0.
- credit  out  WEIGHT_BITS  pops remaining in the current turn (registered).
- pop_err  out  1  one-cycle pulse: pop seen while selector_enb=0.

Behaviour:
- Reset (rst=0, asynchronous): selector=0, selector_enb=0, grant=0, credit=0, pop_err=0, internal pointer ptr=0. Outputs hold these values until the first rising edge after rst returns to 1.
- enb=0: ptr, selector, selector_enb, grant and credit hold; pop is ignored; pop_err=0.
- Eligibility: queue q is eligible when queue_mask[q]=1 and buf_empty[q]=0.
- Search: combinational. Scans ptr, ptr+1, …, ptr+N-1, each index taken modulo QUEUE_QUANTITY with explicit wrap (no power-of-two truncation). First eligible index wins.
- Effective weight: w_eff(q) = 1 when WEIGHTED=0 or weights[q]=0; otherwise weights[q].
- State IDLE (selector_enb=0), each enb cycle:
  - Eligible queue q found: next edge sets selector=q, selector_enb=1, grant=onehot(q), credit=w_eff(q).
  - None found: all state holds.
  - Latency from first eligibility to selector_enb=1 is 1 cycle.
- State GRANT (selector_enb=1), each enb cycle, with s = selector. Evaluated in priority order:
  1. buf_empty[s]=1 or queue_mask[s]=0: release. Next edge sets selector_enb=0, grant=0, credit=0, ptr=(s+1) mod N. Selector keeps its last value. Any pop in the same cycle is still accepted and not flagged.
  2. pop=1 and credit=1: turn ends. Release exactly as in rule 1.
  3. pop=1 and credit>1: credit decrements by 1; grant holds.
  4. pop=0: hold.
- Every turn change passes through exactly one IDLE cycle (one-cycle bubble). This absorbs buf_empty lag after the final pop.
- A weight change during a turn has no effect until the next grant; credit is loaded only on entry to GRANT.
- pop=1 with enb=1 while selector_enb=0: pop_err=1 on the next cycle for one cycle; no other state changes.
- Fairness: after releasing queue s, the next search starts at s+1. A continuously eligible queue therefore waits at most (N-1) turns.
- Reset mid-turn: grant drops immediately (asynchronous); after reset, arbitration restarts from queue 0.

Test Plan:
- N=4, all queues non-empty, mask=1111, weights={1,1,1,1}, pop every GRANT cycle -> selector sequence 0,1,2,3,0,…; one IDLE cycle between grants; credit=1 on each grant.
- N=4, weights q0=3, q1=1, q2=2, q3=0, all non-empty, continuous pop -> pops per turn: q0 three, q1 one, q2 two, q3 one (weight 0 becomes 1); with WEIGHTED=0 every turn is one pop.
- N=3 (non-power-of-two), only q2 and q0 non-empty, ptr after q2 -> wraps to q0 (never index 3); grant alternates 100, 001.
- q1 granted with credit=3; buf_empty[1] rises after one pop -> selector_enb=0 next edge, ptr=2; next grant goes to the first eligible queue from q2.
- pop pulsed while idle -> pop_err=1 for one cycle, selector_enb stays 0; enb=0 mid-turn with pop=1 -> credit and grant unchanged.
- Assert rst=0 asynchronously mid-turn on q2 -> selector=0, selector_enb=0, grant=0000 before the next edge; after release, first grant is the lowest-index eligible queue at or after q0.
